risc_mgmt_ext_exec_ctrl: RTL and testbench

- Execute-stage sequencer between RISC-MGMT and N_EXT custom-instruction extensions; successor to the single-extension execute channel.
- Latches operands and PC, issues to one selected extension, and waits out multi-cycle busy with a timeout watchdog.
- Captures that extension's result, branch/jump and exception; presents them to the pipeline with a stall/done handshake.

---
 rtl/risc_mgmt_ext_exec_ctrl_if.sv | 52 +++++
 rtl/risc_mgmt_ext_exec_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_risc_mgmt_ext_exec_ctrl.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/risc_mgmt_ext_exec_ctrl_if.sv
// Bundle of pipeline-side and extension-side signals for the extension
// execute controller. The controller connects via the slave modport; the
// pipeline plus the extensions (or a bench standing in for them) connect via master.
interface risc_mgmt_ext_exec_ctrl_if #(
  parameter int N_EXT  = 4,
  parameter int WORD_W = 32,
  parameter int SEL_W  = (N_EXT > 1) ? $clog2(N_EXT) : 1
);
  // pipeline request
  logic                    start;
  logic [SEL_W-1:0]        ext_sel;
  logic [WORD_W-1:0]       rdata_s_0;
  logic [WORD_W-1:0]       rdata_s_1;
  logic [WORD_W-1:0]       pc;
  logic                    flush;
  // extension issue side
  logic [N_EXT-1:0]        ext_start;
  logic [N_EXT-1:0]        ext_abort;
  logic [WORD_W-1:0]       ext_rdata_s_0;
  logic [WORD_W-1:0]       ext_rdata_s_1;
  logic [WORD_W-1:0]       ext_pc;
  // extension status/results
  logic [N_EXT-1:0]        ext_busy;
  logic [N_EXT-1:0]        ext_exception;
  logic [N_EXT-1:0]        ext_reg_w;
  logic [N_EXT-1:0]        ext_branch_jump;
  logic [N_EXT*WORD_W-1:0] ext_reg_wdata;
  logic [N_EXT*WORD_W-1:0] ext_br_j_addr;
  // pipeline results
  logic                    stall;
  logic                    done;
  logic                    reg_w;
  logic                    branch_jump;
  logic                    exception;
  logic                    timeout;
  logic [WORD_W-1:0]       reg_wdata;
  logic [WORD_W-1:0]       br_j_addr;

  modport master (
    output start, ext_sel, rdata_s_0, rdata_s_1, pc, flush,
    output ext_busy, ext_exception, ext_reg_w, ext_branch_jump, ext_reg_wdata, ext_br_j_addr,
    input  ext_start, ext_abort, ext_rdata_s_0, ext_rdata_s_1, ext_pc,
    input  stall, done, reg_w, branch_jump, exception, timeout, reg_wdata, br_j_addr
  );

  modport slave (
    input  start, ext_sel, rdata_s_0, rdata_s_1, pc, flush,
    input  ext_busy, ext_exception, ext_reg_w, ext_branch_jump, ext_reg_wdata, ext_br_j_addr,
    output ext_start, ext_abort, ext_rdata_s_0, ext_rdata_s_1, ext_pc,
    output stall, done, reg_w, branch_jump, exception, timeout, reg_wdata, br_j_addr
  );
endinterface

// File: rtl/risc_mgmt_ext_exec_ctrl.sv
// Execute-stage sequencer issuing custom instructions to one of N_EXT
// extensions, waiting out busy with a watchdog, and returning the result.
// Optional performance counters are enabled by defining RISC_MGMT_EXEC_PERF_EN.
module risc_mgmt_ext_exec_ctrl #(
  parameter int N_EXT          = 4,
  parameter int WORD_W         = 32,
  parameter int SEL_W          = (N_EXT > 1) ? $clog2(N_EXT) : 1,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                     CLK,
  input  logic                     RST,
  risc_mgmt_ext_exec_ctrl_if.slave bus
`ifdef RISC_MGMT_EXEC_PERF_EN
  ,
  output logic [31:0]              perf_ops,
  output logic [31:0]              perf_busy_cycles
`endif
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [SEL_W:0]   N_EXT_W  = (SEL_W + 1)'(N_EXT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t             state_r, state_s;
  logic [SEL_W-1:0]   sel_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [N_EXT-1:0]   ext_start_r;
  logic [N_EXT-1:0]   abort_s;
  logic               stall_s;
  logic [WORD_W-1:0]  op0_r, op1_r, pc_r;
  logic               reg_w_r, branch_jump_r, exception_r, timeout_r;
  logic [WORD_W-1:0]  reg_wdata_r, br_j_addr_r;

  logic               sel_ok_s;
  logic               busy_sel_s;
  logic               tmo_s;
  logic [N_EXT-1:0]   sel_onehot_s;

  assign sel_ok_s     = ({1'b0, bus.ext_sel} < N_EXT_W);
  assign busy_sel_s   = bus.ext_busy[sel_r];
  assign tmo_s        = busy_sel_s && (cnt_r == CNT_LAST);
  assign sel_onehot_s = N_EXT'(1) << sel_r;

  assign bus.ext_start     = ext_start_r;
  assign bus.ext_abort     = abort_s;
  assign bus.stall         = stall_s;
  assign bus.done          = (state_r == ST_DONE);
  assign bus.ext_rdata_s_0 = op0_r;
  assign bus.ext_rdata_s_1 = op1_r;
  assign bus.ext_pc        = pc_r;
  assign bus.reg_w         = reg_w_r;
  assign bus.branch_jump   = branch_jump_r;
  assign bus.exception     = exception_r;
  assign bus.timeout       = timeout_r;
  assign bus.reg_wdata     = reg_wdata_r;
  assign bus.br_j_addr     = br_j_addr_r;

  // Next-state, stall and abort decode; flush overrides every other transition.
  always_comb begin
    state_s = state_r;
    abort_s = '0;
    stall_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        stall_s = bus.start;
        if (bus.flush) begin
          state_s = ST_IDLE;
        end else if (bus.start) begin
          state_s = sel_ok_s ? ST_ISSUE : ST_DONE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        stall_s = 1'b1;
        if (bus.flush) begin
          abort_s = sel_onehot_s;
          state_s = ST_IDLE;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_WAIT: begin
        stall_s = 1'b1;
        if (bus.flush) begin
          abort_s = sel_onehot_s;
          state_s = ST_IDLE;
        end else if (!busy_sel_s) begin
          state_s = ST_DONE;
        end else if (tmo_s) begin
          abort_s = sel_onehot_s;
          state_s = ST_DONE;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, operand latch, watchdog counter and result capture.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r       <= ST_IDLE;
      sel_r         <= '0;
      cnt_r         <= '0;
      ext_start_r   <= '0;
      op0_r         <= '0;
      op1_r         <= '0;
      pc_r          <= '0;
      reg_w_r       <= 1'b0;
      branch_jump_r <= 1'b0;
      exception_r   <= 1'b0;
      timeout_r     <= 1'b0;
      reg_wdata_r   <= '0;
      br_j_addr_r   <= '0;
    end else begin
      state_r     <= state_s;
      ext_start_r <= '0;
      case (state_r)
        ST_IDLE: begin
          if (!bus.flush && bus.start) begin
            if (sel_ok_s) begin
              sel_r       <= bus.ext_sel;
              op0_r       <= bus.rdata_s_0;
              op1_r       <= bus.rdata_s_1;
              pc_r        <= bus.pc;
              cnt_r       <= '0;
              ext_start_r <= N_EXT'(1) << bus.ext_sel;
            end else begin
              // No such extension: report an exception without issuing.
              reg_w_r       <= 1'b0;
              branch_jump_r <= 1'b0;
              exception_r   <= 1'b1;
              timeout_r     <= 1'b0;
              reg_wdata_r   <= '0;
              br_j_addr_r   <= '0;
            end
          end
        end
        ST_ISSUE: begin
          cnt_r <= '0;
        end
        ST_WAIT: begin
          if (!bus.flush) begin
            if (!busy_sel_s) begin
              // An excepting extension must not write back or redirect.
              reg_w_r       <= bus.ext_reg_w[sel_r] & ~bus.ext_exception[sel_r];
              branch_jump_r <= bus.ext_branch_jump[sel_r] & ~bus.ext_exception[sel_r];
              exception_r   <= bus.ext_exception[sel_r];
              timeout_r     <= 1'b0;
              reg_wdata_r   <= bus.ext_reg_wdata[int'(sel_r)*WORD_W +: WORD_W];
              br_j_addr_r   <= bus.ext_br_j_addr[int'(sel_r)*WORD_W +: WORD_W];
            end else if (tmo_s) begin
              reg_w_r       <= 1'b0;
              branch_jump_r <= 1'b0;
              exception_r   <= 1'b1;
              timeout_r     <= 1'b1;
              reg_wdata_r   <= '0;
              br_j_addr_r   <= '0;
            end else begin
              cnt_r <= cnt_r + CNT_W'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef RISC_MGMT_EXEC_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    if (v == 32'hFFFF_FFFF) begin
      return v;
    end else begin
      return v + 32'd1;
    end
  endfunction

  // Saturating completion and busy-wait counters.
  always_ff @(posedge CLK) begin
    if (RST) begin
      perf_ops         <= 32'd0;
      perf_busy_cycles <= 32'd0;
    end else begin
      if (state_r == ST_DONE) begin
        perf_ops <= sat_inc(perf_ops);
      end
      if ((state_r == ST_WAIT) && busy_sel_s) begin
        perf_busy_cycles <= sat_inc(perf_busy_cycles);
      end
    end
  end
`endif

endmodule

// File: tb/tb_risc_mgmt_ext_exec_ctrl.sv
// Directed self-checking bench for risc_mgmt_ext_exec_ctrl.
// dut_a: N_EXT=4, default watchdog; dut_b: N_EXT=3, TIMEOUT_CYCLES=8.
module tb_risc_mgmt_ext_exec_ctrl;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  risc_mgmt_ext_exec_ctrl_if #(.N_EXT(4), .WORD_W(32), .SEL_W(2)) ifa ();
  risc_mgmt_ext_exec_ctrl_if #(.N_EXT(3), .WORD_W(32), .SEL_W(2)) ifb ();

`ifdef RISC_MGMT_EXEC_PERF_EN
  logic [31:0] perf_ops_a, perf_busy_a, perf_ops_b, perf_busy_b;
`endif

  risc_mgmt_ext_exec_ctrl #(.N_EXT(4), .WORD_W(32), .SEL_W(2), .TIMEOUT_CYCLES(256)) dut_a (
    .CLK(clk), .RST(rst), .bus(ifa)
`ifdef RISC_MGMT_EXEC_PERF_EN
    , .perf_ops(perf_ops_a), .perf_busy_cycles(perf_busy_a)
`endif
  );

  risc_mgmt_ext_exec_ctrl #(.N_EXT(3), .WORD_W(32), .SEL_W(2), .TIMEOUT_CYCLES(8)) dut_b (
    .CLK(clk), .RST(rst), .bus(ifb)
`ifdef RISC_MGMT_EXEC_PERF_EN
    , .perf_ops(perf_ops_b), .perf_busy_cycles(perf_busy_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ifa.start = 1'b0; ifa.ext_sel = 2'd0; ifa.flush = 1'b0;
    ifa.rdata_s_0 = 32'd0; ifa.rdata_s_1 = 32'd0; ifa.pc = 32'd0;
    ifa.ext_busy = 4'd0; ifa.ext_exception = 4'd0; ifa.ext_reg_w = 4'd0; ifa.ext_branch_jump = 4'd0;
    ifa.ext_reg_wdata = 128'd0; ifa.ext_br_j_addr = 128'd0;
    ifb.start = 1'b0; ifb.ext_sel = 2'd0; ifb.flush = 1'b0;
    ifb.rdata_s_0 = 32'd0; ifb.rdata_s_1 = 32'd0; ifb.pc = 32'd0;
    ifb.ext_busy = 3'd0; ifb.ext_exception = 3'd0; ifb.ext_reg_w = 3'd0; ifb.ext_branch_jump = 3'd0;
    ifb.ext_reg_wdata = 96'd0; ifb.ext_br_j_addr = 96'd0;
    step(); step();
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({ifa.done, ifa.stall, ifa.reg_w, ifa.branch_jump, ifa.exception, ifa.timeout} !== 6'b000000) begin
      n_bad++; $display("FAIL reset_flags got %b exp 000000",
        {ifa.done, ifa.stall, ifa.reg_w, ifa.branch_jump, ifa.exception, ifa.timeout});
    end
    n_cmp++;
    if ({ifa.ext_start, ifa.ext_abort} !== 8'h00) begin
      n_bad++; $display("FAIL reset_start_abort got %h exp 00", {ifa.ext_start, ifa.ext_abort});
    end
    n_cmp++;
    if ({ifa.reg_wdata, ifa.br_j_addr, ifa.ext_pc, ifa.ext_rdata_s_0} !== 128'd0) begin
      n_bad++; $display("FAIL reset_data got %h exp 0", {ifa.reg_wdata, ifa.br_j_addr, ifa.ext_pc, ifa.ext_rdata_s_0});
    end
    n_cmp++;
    if ({ifb.done, ifb.exception, ifb.ext_start} !== 5'b00000) begin
      n_bad++; $display("FAIL reset_b got %b exp 00000", {ifb.done, ifb.exception, ifb.ext_start});
    end
  endtask

  task automatic test_single_cycle();
    ifa.ext_busy = 4'b0000; ifa.ext_reg_w = 4'b0100;
    ifa.ext_reg_wdata = {32'h0, 32'h0000_000C, 32'hDEAD_BEEF, 32'h1111_1111};
    step();
    ifa.start = 1'b1; ifa.ext_sel = 2'd2;
    ifa.rdata_s_0 = 32'h5; ifa.rdata_s_1 = 32'h7; ifa.pc = 32'h100;
    #1;
    n_cmp++;
    if (ifa.stall !== 1'b1) begin n_bad++; $display("FAIL single_stall_t0 got %b exp 1", ifa.stall); end
    step();
    ifa.start = 1'b0;
    #1;
    n_cmp++;
    if (ifa.ext_start !== 4'b0100) begin n_bad++; $display("FAIL single_ext_start got %b exp 0100", ifa.ext_start); end
    n_cmp++;
    if ({ifa.ext_rdata_s_0, ifa.ext_rdata_s_1, ifa.ext_pc} !== {32'h5, 32'h7, 32'h100}) begin
      n_bad++; $display("FAIL single_operands got %h exp 5/7/100", {ifa.ext_rdata_s_0, ifa.ext_rdata_s_1, ifa.ext_pc});
    end
    step();
    #1;
    n_cmp++;
    if ({ifa.stall, ifa.done, ifa.ext_start} !== 6'b100000) begin
      n_bad++; $display("FAIL single_t2 got %b exp 100000", {ifa.stall, ifa.done, ifa.ext_start});
    end
    step();
    #1;
    n_cmp++;
    if ({ifa.done, ifa.stall, ifa.reg_w, ifa.exception} !== 4'b1010) begin
      n_bad++; $display("FAIL single_done_flags got %b exp 1010", {ifa.done, ifa.stall, ifa.reg_w, ifa.exception});
    end
    n_cmp++;
    if (ifa.reg_wdata !== 32'h0000_000C) begin n_bad++; $display("FAIL single_wdata got %h exp 0000000c", ifa.reg_wdata); end
    step();
    #1;
    n_cmp++;
    if ({ifa.done, ifa.reg_wdata} !== {1'b0, 32'h0000_000C}) begin
      n_bad++; $display("FAIL single_hold got %h exp 0000000c with done 0", {ifa.done, ifa.reg_wdata});
    end
  endtask

  task automatic test_multi_cycle();
    ifa.ext_busy = 4'b0010; ifa.ext_reg_w = 4'b0000; ifa.ext_branch_jump = 4'b0010;
    ifa.ext_br_j_addr = {32'h0, 32'h0, 32'h0000_0400, 32'h0};
    step();
    ifa.start = 1'b1; ifa.ext_sel = 2'd1;
    step();
    ifa.start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      #1;
      n_cmp++;
      if ({ifa.stall, ifa.done} !== 2'b10) begin
        n_bad++; $display("FAIL multi_wait%0d got %b exp 10", i, {ifa.stall, ifa.done});
      end
    end
    step();
    ifa.ext_busy = 4'b0000;
    #1;
    n_cmp++;
    if ({ifa.stall, ifa.done} !== 2'b10) begin n_bad++; $display("FAIL multi_t12 got %b exp 10", {ifa.stall, ifa.done}); end
    step();
    #1;
    n_cmp++;
    if ({ifa.done, ifa.branch_jump, ifa.reg_w, ifa.exception, ifa.timeout} !== 5'b11000) begin
      n_bad++; $display("FAIL multi_done_flags got %b exp 11000",
        {ifa.done, ifa.branch_jump, ifa.reg_w, ifa.exception, ifa.timeout});
    end
    n_cmp++;
    if (ifa.br_j_addr !== 32'h0000_0400) begin n_bad++; $display("FAIL multi_addr got %h exp 00000400", ifa.br_j_addr); end
    ifa.ext_branch_jump = 4'b0000;
  endtask

  task automatic test_flush();
    // flush while in ISSUE: issue and abort in the same cycle
    ifa.ext_busy = 4'b0100;
    step();
    ifa.start = 1'b1; ifa.ext_sel = 2'd2;
    step();
    ifa.start = 1'b0; ifa.flush = 1'b1;
    #1;
    n_cmp++;
    if ({ifa.ext_start, ifa.ext_abort} !== 8'b0100_0100) begin
      n_bad++; $display("FAIL flush_issue got %b exp 01000100", {ifa.ext_start, ifa.ext_abort});
    end
    step();
    ifa.flush = 1'b0;
    #1;
    n_cmp++;
    if ({ifa.stall, ifa.done} !== 2'b00) begin n_bad++; $display("FAIL flush_issue_idle got %b exp 00", {ifa.stall, ifa.done}); end
    // flush in the third WAIT cycle
    step();
    ifa.start = 1'b1; ifa.ext_sel = 2'd2;
    step();
    ifa.start = 1'b0;
    step();
    step();
    step();
    ifa.flush = 1'b1;
    #1;
    n_cmp++;
    if (ifa.ext_abort !== 4'b0100) begin n_bad++; $display("FAIL flush_wait_abort got %b exp 0100", ifa.ext_abort); end
    step();
    ifa.flush = 1'b0;
    #1;
    n_cmp++;
    if ({ifa.stall, ifa.done, ifa.ext_abort} !== 6'b000000) begin
      n_bad++; $display("FAIL flush_wait_idle got %b exp 000000", {ifa.stall, ifa.done, ifa.ext_abort});
    end
    // fresh start two cycles after the flush
    step();
    ifa.ext_busy = 4'b0000; ifa.ext_reg_w = 4'b0100;
    ifa.ext_reg_wdata = {32'h0, 32'h0000_0055, 32'h0, 32'h0};
    ifa.start = 1'b1; ifa.ext_sel = 2'd2;
    #1;
    n_cmp++;
    if ({ifa.done, ifa.stall} !== 2'b01) begin n_bad++; $display("FAIL flush_restart_t0 got %b exp 01", {ifa.done, ifa.stall}); end
    step();
    ifa.start = 1'b0;
    step();
    step();
    #1;
    n_cmp++;
    if ({ifa.done, ifa.reg_w, ifa.reg_wdata} !== {2'b11, 32'h0000_0055}) begin
      n_bad++; $display("FAIL flush_restart_done got %h exp 3_00000055", {ifa.done, ifa.reg_w, ifa.reg_wdata});
    end
  endtask

  task automatic test_ext_exception();
    ifa.ext_busy = 4'b0000; ifa.ext_reg_w = 4'b1000; ifa.ext_branch_jump = 4'b1000; ifa.ext_exception = 4'b1000;
    ifa.ext_reg_wdata = {32'h0000_0077, 32'h0, 32'h0, 32'h0};
    step();
    ifa.start = 1'b1; ifa.ext_sel = 2'd3;
    step();
    ifa.start = 1'b0;
    step();
    step();
    #1;
    n_cmp++;
    if ({ifa.done, ifa.exception, ifa.reg_w, ifa.branch_jump, ifa.timeout} !== 5'b11000) begin
      n_bad++; $display("FAIL exc_flags got %b exp 11000",
        {ifa.done, ifa.exception, ifa.reg_w, ifa.branch_jump, ifa.timeout});
    end
    n_cmp++;
    if (ifa.reg_wdata !== 32'h0000_0077) begin n_bad++; $display("FAIL exc_wdata got %h exp 00000077", ifa.reg_wdata); end
    ifa.ext_exception = 4'b0000; ifa.ext_reg_w = 4'b0000; ifa.ext_branch_jump = 4'b0000;
    step();
    #1;
`ifdef RISC_MGMT_EXEC_PERF_EN
    // four completions and 13 busy WAIT cycles on dut_a so far
    n_cmp++;
    if (perf_ops_a !== 32'd4) begin n_bad++; $display("FAIL perf_ops got %0d exp 4", perf_ops_a); end
    n_cmp++;
    if (perf_busy_a !== 32'd13) begin n_bad++; $display("FAIL perf_busy got %0d exp 13", perf_busy_a); end
`endif
  endtask

  task automatic test_timeout();
    logic [2:0] exp_abort;
    ifb.ext_busy = 3'b001;
    step();
    ifb.start = 1'b1; ifb.ext_sel = 2'd0;
    step();
    ifb.start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      #1;
      exp_abort = (k == 8) ? 3'b001 : 3'b000;
      n_cmp++;
      if ({ifb.ext_abort, ifb.done} !== {exp_abort, 1'b0}) begin
        n_bad++; $display("FAIL tmo_wait%0d got %b exp %b", k, {ifb.ext_abort, ifb.done}, {exp_abort, 1'b0});
      end
    end
    step();
    #1;
    n_cmp++;
    if ({ifb.done, ifb.exception, ifb.timeout, ifb.reg_w, ifb.ext_abort} !== 7'b1110000) begin
      n_bad++; $display("FAIL tmo_done got %b exp 1110000",
        {ifb.done, ifb.exception, ifb.timeout, ifb.reg_w, ifb.ext_abort});
    end
    ifb.ext_busy = 3'b000;
  endtask

  task automatic test_bad_sel();
    step();
    ifb.start = 1'b1; ifb.ext_sel = 2'd3;
    #1;
    n_cmp++;
    if ({ifb.stall, ifb.done} !== 2'b10) begin n_bad++; $display("FAIL badsel_t0 got %b exp 10", {ifb.stall, ifb.done}); end
    step();
    ifb.start = 1'b0;
    #1;
    n_cmp++;
    if ({ifb.done, ifb.exception, ifb.timeout, ifb.ext_start} !== 6'b110000) begin
      n_bad++; $display("FAIL badsel_done got %b exp 110000", {ifb.done, ifb.exception, ifb.timeout, ifb.ext_start});
    end
    step();
    #1;
    n_cmp++;
    if ({ifb.done, ifb.stall, ifb.ext_start} !== 5'b00000) begin
      n_bad++; $display("FAIL badsel_after got %b exp 00000", {ifb.done, ifb.stall, ifb.ext_start});
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_single_cycle();
    test_multi_cycle();
    test_flush();
    test_ext_exception();
    test_timeout();
    test_bad_sel();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog sim time exceeded, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end
endmodule
